// File: rtl/ysyx_25040109_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, store lengths
// and the latched memory request record.
package ysyx_25040109_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [2:0] WLEN_B = 3'd1;
    localparam logic [2:0] WLEN_H = 3'd2;
    localparam logic [2:0] WLEN_W = 3'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [2:0]  wlen;
    } mem_req_t;

    // Instruction fetches are always full-word reads.
    function automatic mem_req_t ifu_fetch(input logic [31:0] addr);
        mem_req_t r;
        r.addr  = addr;
        r.wen   = 1'b0;
        r.wdata = 32'd0;
        r.wlen  = WLEN_W;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_25040109_arb_pick.sv
// Two-way grant: fixed LSU priority, or round-robin when YSYX_25040109_ARB_RR_EN is defined.
// Purely combinational; the caller decides when the grant is taken.
module ysyx_25040109_arb_pick
    import ysyx_25040109_pkg::*;
(
    input  logic ifu_vld_i,
    input  logic lsu_vld_i,
`ifdef YSYX_25040109_ARB_RR_EN
    input  logic ptr_lsu_i,
`endif
    output logic gnt_vld_o,
    output logic gnt_own_o
);

    always_comb begin
        gnt_vld_o = ifu_vld_i | lsu_vld_i;
`ifdef YSYX_25040109_ARB_RR_EN
        // LSU wins when it is favoured by the pointer or when it has no competitor.
        if (lsu_vld_i && (ptr_lsu_i || !ifu_vld_i)) begin
            gnt_own_o = OWN_LSU;
        end else begin
            gnt_own_o = OWN_IFU;
        end
`else
        gnt_own_o = lsu_vld_i ? OWN_LSU : OWN_IFU;
`endif
    end

endmodule

// File: rtl/ysyx_25040109_mem_arb.sv
// Arbitrates IFU and LSU onto one memory port, one transaction at a time (optional RR: YSYX_25040109_ARB_RR_EN).
// Latency: accept -> mem handshake -> mem resp -> resp_valid, minimum 3 cycles; next accept on the resp_valid cycle.
// Backpressure: requesters are only ready in IDLE; the latched request is held until mem_req_ready.
module ysyx_25040109_mem_arb
    import ysyx_25040109_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [2:0]  lsu_wlen,
    output logic        lsu_resp_valid,

    output logic [31:0] resp_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_wlen,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    mem_req_t    req_q, req_d;
    logic        ifu_resp_q, ifu_resp_d;
    logic        lsu_resp_q, lsu_resp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        gnt_vld;
    logic        gnt_own;
    logic        grant;

`ifdef YSYX_25040109_ARB_RR_EN
    logic        ptr_lsu_q, ptr_lsu_d;
`endif

    ysyx_25040109_arb_pick u_pick (
        .ifu_vld_i (ifu_req_valid),
        .lsu_vld_i (lsu_req_valid),
`ifdef YSYX_25040109_ARB_RR_EN
        .ptr_lsu_i (ptr_lsu_q),
`endif
        .gnt_vld_o (gnt_vld),
        .gnt_own_o (gnt_own)
    );

    assign grant         = (state_q == ST_IDLE) && gnt_vld;
    assign ifu_req_ready = grant && (gnt_own == OWN_IFU);
    assign lsu_req_ready = grant && (gnt_own == OWN_LSU);

    assign mem_req_valid  = (state_q == ST_REQ);
    assign mem_addr       = req_q.addr;
    assign mem_wen        = req_q.wen;
    assign mem_wdata      = req_q.wdata;
    assign mem_wlen       = req_q.wlen;

    assign ifu_resp_valid = ifu_resp_q;
    assign lsu_resp_valid = lsu_resp_q;
    assign resp_rdata     = rdata_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_d      = req_q;
        ifu_resp_d = 1'b0;
        lsu_resp_d = 1'b0;
        rdata_d    = rdata_q;
`ifdef YSYX_25040109_ARB_RR_EN
        ptr_lsu_d  = ptr_lsu_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_own;
                    if (gnt_own == OWN_LSU) begin
                        req_d.addr  = lsu_addr;
                        req_d.wen   = lsu_wen;
                        req_d.wdata = lsu_wdata;
                        req_d.wlen  = lsu_wlen;
                    end else begin
                        req_d = ifu_fetch(ifu_addr);
                    end
`ifdef YSYX_25040109_ARB_RR_EN
                    // Hand priority to whoever did not just win.
                    ptr_lsu_d = (gnt_own == OWN_IFU);
`endif
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d    = mem_rdata;
                    ifu_resp_d = (owner_q == OWN_IFU);
                    lsu_resp_d = (owner_q == OWN_LSU);
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IFU;
            req_q      <= '0;
            ifu_resp_q <= 1'b0;
            lsu_resp_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            ifu_resp_q <= ifu_resp_d;
            lsu_resp_q <= lsu_resp_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef YSYX_25040109_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_lsu_q <= 1'b1;
        end else begin
            ptr_lsu_q <= ptr_lsu_d;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25040109_mem_arb.sv
// Scoreboard bench for ysyx_25040109_mem_arb: directed requests, a memory model that checks
// the forwarded request, and a monitor that checks every response pulse against a queue.
module tb_ysyx_25040109_mem_arb;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_L = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [2:0]  lsu_wlen;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_wlen;

    logic        mresp_vld, force_vld;
    logic [31:0] mresp_dat, force_dat;
    assign mem_resp_valid = mresp_vld | force_vld;
    assign mem_rdata      = force_vld ? force_dat : mresp_dat;

    always #5 clk = ~clk;

    ysyx_25040109_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wlen(lsu_wlen), .lsu_resp_valid(lsu_resp_valid),
        .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wlen(mem_wlen), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [2:0]  wlen;
        logic [31:0] rdata;
    } mreq_t;

    typedef struct {
        logic        own;
        logic [31:0] rdata;
    } resp_t;

    mreq_t exp_mreq[$];
    resp_t exp_resp[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_delay = 0;
    int resp_delay = 0;
    int last_ifu_resp_cyc = -1;
    int last_lsu_resp_cyc = -1;
    logic [31:0] last_rdata = 32'd0;
    int acc_i, acc_i2, acc_l, acc_l2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_mreq(input string n, input mreq_t m);
        check32({n, "_vld"},  {31'd0, mem_req_valid}, 32'd1);
        check32({n, "_addr"}, mem_addr, m.addr);
        check32({n, "_wen"},  {31'd0, mem_wen}, {31'd0, m.wen});
        if (m.wen) check32({n, "_wdata"}, mem_wdata, m.wdata);
        check32({n, "_wlen"}, {29'd0, mem_wlen}, {29'd0, m.wlen});
    endtask

    task automatic check_zero_outputs(input string n);
        check32({n, "_ready"},  {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
        check32({n, "_respv"},  {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
        check32({n, "_rdata"},  resp_rdata, 32'd0);
        check32({n, "_mvld"},   {31'd0, mem_req_valid}, 32'd0);
        check32({n, "_maddr"},  mem_addr, 32'd0);
        check32({n, "_mwdata"}, mem_wdata, 32'd0);
        check32({n, "_mctl"},   {28'd0, mem_wen, mem_wlen}, 32'd0);
    endtask

    task automatic expect_txn(input logic own, input logic [31:0] a, input logic w,
                              input logic [31:0] wd, input logic [2:0] wl,
                              input logic [31:0] rd, input logic want_resp);
        mreq_t m;
        resp_t r;
        m.addr = a; m.wen = w; m.wdata = wd; m.wlen = wl; m.rdata = rd;
        exp_mreq.push_back(m);
        if (want_resp) begin
            r.own = own; r.rdata = rd;
            exp_resp.push_back(r);
        end
    endtask

    task automatic ifu_send(input logic [31:0] a, output int acc);
        logic ok;
        ok = 1'b0;
        acc = -1;
        ifu_req_valid = 1'b1;
        ifu_addr = a;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (ifu_req_ready) begin ok = 1'b1; acc = cyc; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ifu_accept: ifu_req_ready never seen for addr %h, expected acceptance", a);
        end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_send(input logic [31:0] a, input logic w, input logic [31:0] wd,
                            input logic [2:0] wl, output int acc);
        logic ok;
        ok = 1'b0;
        acc = -1;
        lsu_req_valid = 1'b1;
        lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wlen = wl;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (lsu_req_ready) begin ok = 1'b1; acc = cyc; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lsu_accept: lsu_req_ready never seen for addr %h, expected acceptance", a);
        end
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string n);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk); #1;
            if (exp_mreq.size() == 0 && exp_resp.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: %0d responses still pending, expected 0", n, exp_resp.size());
        end
    endtask

    // Memory model: checks the forwarded request and answers with the expected read data.
    initial begin
        mreq_t m;
        mem_req_ready = 1'b0;
        mresp_vld = 1'b0;
        mresp_dat = 32'd0;
        forever begin
            @(posedge clk); #1;
            mresp_vld = 1'b0;
            if (mem_req_valid) begin
                if (exp_mreq.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL mreq_unexpected: request to %h, expected none", mem_addr);
                    m.addr = mem_addr; m.wen = mem_wen; m.wdata = mem_wdata;
                    m.wlen = mem_wlen; m.rdata = 32'd0;
                end else begin
                    m = exp_mreq.pop_front();
                end
                for (int i = 0; i < ready_delay; i++) begin
                    @(negedge clk);
                    chk_mreq("mreq_hold", m);
                    @(posedge clk); #1;
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                chk_mreq("mreq", m);
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                for (int i = 0; i < resp_delay; i++) begin
                    @(posedge clk); #1;
                end
                mresp_vld = 1'b1;
                mresp_dat = m.rdata;
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        logic  prev_mresp;
        prev_mresp = 1'b0;
        forever begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready)
                check32("ready_onehot", {31'd0, ifu_req_ready & lsu_req_ready}, 32'd0);
            if (ifu_resp_valid || lsu_resp_valid) begin
                check32("resp_onehot", {31'd0, ifu_resp_valid & lsu_resp_valid}, 32'd0);
                check32("resp_after_mem", {31'd0, prev_mresp}, 32'd1);
                if (exp_resp.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL resp_unexpected: ifu=%b lsu=%b rdata=%h, expected no pulse",
                             ifu_resp_valid, lsu_resp_valid, resp_rdata);
                end else begin
                    e = exp_resp.pop_front();
                    check32("resp_owner", {31'd0, lsu_resp_valid}, {31'd0, e.own});
                    check32("resp_rdata", resp_rdata, e.rdata);
                    last_rdata = e.rdata;
                end
                if (ifu_resp_valid) last_ifu_resp_cyc = cyc;
                if (lsu_resp_valid) last_lsu_resp_cyc = cyc;
            end
            prev_mresp = mem_resp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'd0;
        lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0;
        lsu_wdata = 32'd0; lsu_wlen = 3'd0;
        force_vld = 1'b0; force_dat = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // Spurious memory response while idle must be ignored.
        @(posedge clk); #1;
        force_vld = 1'b1; force_dat = 32'hDEADBEEF;
        @(posedge clk); #1;
        force_vld = 1'b0;
        @(negedge clk);
        check32("spurious_rdata", resp_rdata, 32'd0);
        check32("spurious_mvld", {31'd0, mem_req_valid}, 32'd0);
        @(posedge clk); #1;

        // IFU-only fetch: 3-cycle latency, wen=0, wlen=4.
        ready_delay = 0; resp_delay = 0;
        expect_txn(OWN_I, 32'h80000000, 1'b0, 32'd0, 3'd4, 32'h00000413, 1'b1);
        ifu_send(32'h80000000, acc_i);
        wait_drain("ifu_only");
        check32("ifu_latency", 32'(last_ifu_resp_cyc - acc_i), 32'd3);

        // Simultaneous IFU fetch and LSU load: LSU first, IFU accepted as LSU responds.
        expect_txn(OWN_L, 32'h80001000, 1'b0, 32'd0, 3'd4, 32'h11112222, 1'b1);
        expect_txn(OWN_I, 32'h80001000, 1'b0, 32'd0, 3'd4, 32'h33334444, 1'b1);
        fork
            lsu_send(32'h80001000, 1'b0, 32'd0, 3'd4, acc_l);
            ifu_send(32'h80001000, acc_i);
        join
        wait_drain("simul");
        check32("simul_ifu_accept", 32'(acc_i), 32'(last_lsu_resp_cyc));

        // Four back-to-back transactions with both requesters always valid.
`ifdef YSYX_25040109_ARB_RR_EN
        expect_txn(OWN_L, 32'h80003000, 1'b0, 32'd0,        3'd4, 32'hA0000001, 1'b1);
        expect_txn(OWN_I, 32'h80000010, 1'b0, 32'd0,        3'd4, 32'hA0000002, 1'b1);
        expect_txn(OWN_L, 32'h80003004, 1'b1, 32'h5555AAAA, 3'd1, 32'hA0000003, 1'b1);
        expect_txn(OWN_I, 32'h80000014, 1'b0, 32'd0,        3'd4, 32'hA0000004, 1'b1);
`else
        expect_txn(OWN_L, 32'h80003000, 1'b0, 32'd0,        3'd4, 32'hA0000001, 1'b1);
        expect_txn(OWN_L, 32'h80003004, 1'b1, 32'h5555AAAA, 3'd1, 32'hA0000002, 1'b1);
        expect_txn(OWN_I, 32'h80000010, 1'b0, 32'd0,        3'd4, 32'hA0000003, 1'b1);
        expect_txn(OWN_I, 32'h80000014, 1'b0, 32'd0,        3'd4, 32'hA0000004, 1'b1);
`endif
        fork
            begin
                lsu_send(32'h80003000, 1'b0, 32'd0, 3'd4, acc_l);
                lsu_send(32'h80003004, 1'b1, 32'h5555AAAA, 3'd1, acc_l2);
            end
            begin
                ifu_send(32'h80000010, acc_i);
                ifu_send(32'h80000014, acc_i2);
            end
        join
        wait_drain("four");

        // Halfword store with memory stalling 3 cycles before accepting.
        ready_delay = 3;
        expect_txn(OWN_L, 32'h80002002, 1'b1, 32'h0000ABCD, 3'd2, 32'h0000BEEF, 1'b1);
        lsu_send(32'h80002002, 1'b1, 32'h0000ABCD, 3'd2, acc_l);
        wait_drain("store");
        ready_delay = 0;
        check32("store_latency", 32'(last_lsu_resp_cyc - acc_l), 32'd6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rdata_hold", resp_rdata, last_rdata);

        // Reset while waiting for memory; the late response must not surface.
        @(posedge clk); #1;
        resp_delay = 3;
        expect_txn(OWN_L, 32'h80004000, 1'b0, 32'd0, 3'd4, 32'h99999999, 1'b0);
        lsu_send(32'h80004000, 1'b0, 32'd0, 3'd4, acc_l);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_delay = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("rst_wait");

        // FSM must be fully usable after the abandoned transaction.
        @(posedge clk); #1;
        expect_txn(OWN_I, 32'h80000100, 1'b0, 32'd0, 3'd4, 32'h12345678, 1'b1);
        ifu_send(32'h80000100, acc_i);
        wait_drain("post_reset");
        check32("post_reset_latency", 32'(last_ifu_resp_cyc - acc_i), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
